// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Brief    : Six-digit multiplexed 7-segment scanner (mm.ss.cc) with guard gaps
//            and per-frame input snapshot. Define SEG_SCAN_BLANK_EN to blank
//            a leading zero on the min_10 digit.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan #(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned GUARD_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] min_10,
   input  logic [3:0] min_1,
   input  logic [3:0] sec_10,
   input  logic [3:0] sec_1,
   input  logic [3:0] milli_10,
   input  logic [3:0] milli_1,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int unsigned CNT_MAX = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST = 3'd5;

   typedef enum logic [0:0] {
      ST_SHOW  = 1'b0,
      ST_GUARD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0][3:0]  snap_q, snap_d;
   logic [5:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             fs_q, fs_d;
   logic [3:0]       digit;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + CNT_W'(1);
      snap_d  = snap_q;
      fs_d    = 1'b0;

      case (state_q)
         ST_SHOW: begin
            if (cnt_q == DIG_LAST) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
            end
         end
         default: begin
            if (cnt_q == GRD_LAST) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d  = 3'd0;
                  snap_d = {min_10, min_1, sec_10, sec_1, milli_10, milli_1};
                  fs_d   = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
      endcase

      // Outputs are decoded from the next state so the registered pins line
      // up with the FSM cycle they describe.
      digit = snap_d[idx_d];
      an_d  = 6'b111111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      if (state_d == ST_SHOW) begin
         an_d[idx_d] = 1'b0;
         seg_d       = bcd_to_seg(digit);
         dp_d        = !((idx_d == 3'd2) || (idx_d == 3'd4));
`ifdef SEG_SCAN_BLANK_EN
         if ((idx_d == IDX_LAST) && (digit == 4'd0)) begin
            an_d  = 6'b111111;
            seg_d = 7'b1111111;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_GUARD;
         idx_q   <= IDX_LAST;
         cnt_q   <= '0;
         snap_q  <= '0;
         an_q    <= 6'b111111;
         seg_q   <= 7'b1111111;
         dp_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fs_q    <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire
